// File: rtl/sram_arbiter.sv
// sram_arbiter: two-client req/gnt arbiter and one-access-at-a-time sequencer for a
// single-port SRAM with a fixed read latency.
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise client 0
// wins every tie (fixed priority).
module sram_arbiter #(
  parameter int unsigned AW     = 3,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  typedef enum logic [1:0] {StIdle, StIssue, StRwait, StDone} state_e;

  // Counter starts at RD_LAT-1 so RWAIT lasts exactly RD_LAT cycles.
  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          we_q;
  logic          id_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    cnt_q;
  logic          win;
  logic          take;

`ifdef SRAM_ARB_RR_EN
  logic ptr_q;

  // Tie goes to the client the pointer names; otherwise the lone requester wins.
  always_comb begin
    win = (req0 && req1) ? ptr_q : !req0;
  end

  // Pointer moves past the client just served, once its transaction completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (state_q == StDone) begin
      ptr_q <= ~id_q;
    end
  end
`else
  // Fixed priority: client 1 wins only when req0 is low.
  always_comb begin
    win = !req0;
  end
`endif

  // A grant happens in IDLE whenever anyone asks; gated by rst so reset holds gnt low.
  always_comb begin
    take = (state_q == StIdle) && (req0 || req1) && !rst;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (take) state_d = StIssue;
      StIssue: state_d = we_q ? StDone : StRwait;
      StRwait: if (cnt_q == 2'd0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latched command, wait counter and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (take) begin
        we_q    <= win ? we1 : we0;
        id_q    <= win;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      if (state_q == StIssue && !we_q) begin
        cnt_q <= CntInit;
      end else if (state_q == StRwait) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if (state_q == StRwait && cnt_q == 2'd0) begin
        rdata_q <= sram_dout;
      end
    end
  end

  // Outputs decoded from state; the strobes fall as soon as reset forces IDLE.
  always_comb begin
    gnt0      = take && !win;
    gnt1      = take && win;
    ack0      = (state_q == StDone) && !id_q;
    ack1      = (state_q == StDone) && id_q;
    busy      = (state_q != StIdle);
    sram_wr   = (state_q == StIssue) && we_q;
    sram_rd   = (state_q == StIssue) && !we_q;
    sram_addr = addr_q;
    sram_din  = wdata_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: random two-client traffic against a transaction-level model
// (grant decision, fixed latencies, expected memory contents), plus directed reset and
// RD_LAT=3 latency checks on a second instance.
module tb_sram_arbiter;

  localparam int Lat  = 1;
  localparam int Lat3 = 3;
`ifdef SRAM_ARB_RR_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, ack0, ack1, busy, sram_wr, sram_rd;
  logic [7:0] rdata, sram_din, sram_dout;
  logic [2:0] sram_addr;

  logic       b_req0, b_we0;
  logic [2:0] b_addr0;
  logic [7:0] b_wdata0;
  logic       b_gnt0, b_gnt1, b_ack0, b_ack1, b_busy, b_sram_wr, b_sram_rd;
  logic [7:0] b_rdata, b_sram_din, b_sram_dout;
  logic [2:0] b_sram_addr;

  always #5 clk = ~clk;

  sram_arbiter #(.AW(3), .DW(8), .RD_LAT(Lat)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .busy(busy), .sram_wr(sram_wr), .sram_rd(sram_rd),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram_arbiter #(.AW(3), .DW(8), .RD_LAT(Lat3)) dut3 (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(1'b0), .we0(b_we0), .we1(1'b0),
    .addr0(b_addr0), .addr1(3'd0), .wdata0(b_wdata0), .wdata1(8'd0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .ack0(b_ack0), .ack1(b_ack1),
    .rdata(b_rdata), .busy(b_busy), .sram_wr(b_sram_wr), .sram_rd(b_sram_rd),
    .sram_addr(b_sram_addr), .sram_din(b_sram_din), .sram_dout(b_sram_dout)
  );

  // SRAM models: data appears RD_LAT edges after the rd strobe, garbage otherwise.
  logic [7:0] mem [8];
  logic [7:0] pipe [Lat];
  always @(posedge clk) begin
    if (sram_wr) mem[sram_addr] <= sram_din;
    pipe[0] <= sram_rd ? mem[sram_addr] : 8'($urandom);
    for (int k = 1; k < Lat; k++) pipe[k] <= pipe[k-1];
  end
  assign sram_dout = pipe[Lat-1];

  logic [7:0] mem3 [8];
  logic [7:0] pipe3 [Lat3];
  always @(posedge clk) begin
    if (b_sram_wr) mem3[b_sram_addr] <= b_sram_din;
    pipe3[0] <= b_sram_rd ? mem3[b_sram_addr] : 8'($urandom);
    for (int k = 1; k < Lat3; k++) pipe3[k] <= pipe3[k-1];
  end
  assign b_sram_dout = pipe3[Lat3-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference model.
  int         cyc = 0;
  int         free_at = 0;
  int         gnt_cyc = -10;
  int         wr_cyc = -1;
  int         rd_cyc = -1;
  int         ack_cyc = -10;
  bit         ptr = 1'b0;
  bit         ack_id, ack_rd;
  logic [7:0] ack_data, iss_din, undo_data;
  logic [2:0] iss_addr;
  logic [7:0] rdata_m = 8'd0;
  logic [7:0] mdl_mem [8];
  bit         rand_en = 1'b0;
  int         rate = 0;

  task automatic drive_rand();
    if (!req0) begin
      we0    = 1'($urandom);
      addr0  = 3'($urandom);
      wdata0 = 8'($urandom);
      req0   = ($urandom_range(0, 99) < rate);
    end
    if (!req1) begin
      we1    = 1'($urandom);
      addr1  = 3'($urandom);
      wdata1 = 8'($urandom);
      req1   = ($urandom_range(0, 99) < rate);
    end
  endtask

  // One clock: compare at negedge, advance the model, then update stimulus after the edge.
  task automatic tick();
    bit         g0, g1, win, we_m;
    logic [2:0] a_m;
    logic [7:0] d_m;
    @(negedge clk);
    g0 = 1'b0;
    g1 = 1'b0;
    win = 1'b0;
    if (cyc >= free_at && (req0 || req1)) begin
      win = (req0 && req1) ? (Rr ? ptr : 1'b0) : !req0;
      g0 = !win;
      g1 = win;
    end
    check("gnt0", 32'(gnt0), 32'(g0));
    check("gnt1", 32'(gnt1), 32'(g1));
    check("sram_wr", 32'(sram_wr), 32'(cyc == wr_cyc));
    check("sram_rd", 32'(sram_rd), 32'(cyc == rd_cyc));
    if (cyc == wr_cyc || cyc == rd_cyc) check("sram_addr", 32'(sram_addr), 32'(iss_addr));
    if (cyc == wr_cyc) check("sram_din", 32'(sram_din), 32'(iss_din));
    check("ack0", 32'(ack0), 32'(cyc == ack_cyc && !ack_id));
    check("ack1", 32'(ack1), 32'(cyc == ack_cyc && ack_id));
    if (cyc == ack_cyc && ack_rd) rdata_m = ack_data;
    check("rdata", 32'(rdata), 32'(rdata_m));
    check("busy", 32'(busy), 32'(cyc > gnt_cyc && cyc <= ack_cyc));
    if (g0 || g1) begin
      we_m     = win ? we1 : we0;
      a_m      = win ? addr1 : addr0;
      d_m      = win ? wdata1 : wdata0;
      gnt_cyc  = cyc;
      iss_addr = a_m;
      iss_din  = d_m;
      ack_id   = win;
      if (we_m) begin
        wr_cyc      = cyc + 1;
        rd_cyc      = -1;
        ack_cyc     = cyc + 2;
        ack_rd      = 1'b0;
        undo_data   = mdl_mem[a_m];
        mdl_mem[a_m] = d_m;
      end else begin
        rd_cyc   = cyc + 1;
        wr_cyc   = -1;
        ack_cyc  = cyc + 2 + Lat;
        ack_rd   = 1'b1;
        ack_data = mdl_mem[a_m];
      end
      free_at = ack_cyc + 1;
      if (Rr) ptr = !win;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (g0) req0 = 1'b0;
    if (g1) req1 = 1'b0;
    if (rand_en) drive_rand();
  endtask

  // Assert reset mid-cycle, check everything drops at once, release after one edge.
  task automatic do_reset(input string tag);
    logic r0;
    rst = 1'b1;
    #1;
    r0 = req0;
    req0 = 1'b1;
    #1;
    check({tag, "_gnt0"}, 32'(gnt0), 32'd0);
    req0 = r0;
    check({tag, "_gnt1"}, 32'(gnt1), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack0"}, 32'(ack0), 32'd0);
    check({tag, "_ack1"}, 32'(ack1), 32'd0);
    check({tag, "_sram_wr"}, 32'(sram_wr), 32'd0);
    check({tag, "_sram_rd"}, 32'(sram_rd), 32'd0);
    check({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
    check({tag, "_sram_din"}, 32'(sram_din), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    if (wr_cyc == cyc) mdl_mem[iss_addr] = undo_data;  // aborted write never reached SRAM
    @(posedge clk);
    #1;
    rst     = 1'b0;
    free_at = 0;
    gnt_cyc = -10;
    ack_cyc = -10;
    wr_cyc  = -1;
    rd_cyc  = -1;
    ptr     = 1'b0;
    rdata_m = 8'd0;
  endtask

  // One command on the RD_LAT=3 instance; returns cycles from gnt to ack.
  task automatic b_txn(input bit we, input logic [2:0] a, input logic [7:0] d,
                       output int lat, output bit rd_seen);
    b_req0 = 1'b1;
    b_we0 = we;
    b_addr0 = a;
    b_wdata0 = d;
    lat = 0;
    rd_seen = 1'b0;
    @(negedge clk);
    check("b_gnt0", 32'(b_gnt0), 32'd1);
    @(posedge clk);
    #1;
    b_req0 = 1'b0;
    b_addr0 = 3'd0;
    b_wdata0 = 8'd0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1 && b_sram_rd) rd_seen = 1'b1;
      if (b_ack0) begin
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  lat;
    bit  rd_seen;
    rst = 1'b1;
    {req0, req1, we0, we1} = '0;
    {addr0, addr1, wdata0, wdata1} = '0;
    {b_req0, b_we0, b_addr0, b_wdata0} = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Fill every location so later reads have known contents.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        req0 = 1'b1; we0 = 1'b1; addr0 = 3'(k); wdata0 = 8'(k * 17 + 3);
      end else begin
        req1 = 1'b1; we1 = 1'b1; addr1 = 3'(k); wdata1 = 8'(k * 17 + 3);
      end
      repeat (3) tick();
    end

    // Client 0 writes 3E to addr 1, client 1 reads it back.
    req0 = 1'b1; we0 = 1'b1; addr0 = 3'd1; wdata0 = 8'h3E;
    repeat (3) tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd1;
    repeat (4) tick();
    check("rd_after_wr", 32'(rdata), 32'h3E);

    // Saturated contention, then mixed load.
    rand_en = 1'b1;
    rate = 100; repeat (60) tick();
    rate = 30;  repeat (400) tick();
    rate = 80;  repeat (400) tick();
    rand_en = 1'b0;
    repeat (20) tick();

    // Reset during RWAIT of a read: no ack afterwards, then a fresh read completes.
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    tick();
    tick();
    do_reset("rst_rwait");
    repeat (3) tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd2;
    repeat (4) tick();

    // Reset during ISSUE of a write: strobe drops, write is lost.
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd4; wdata1 = 8'hC7;
    tick();
    do_reset("rst_issue");
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd4;
    repeat (4) tick();

    rand_en = 1'b1;
    rate = 60; repeat (300) tick();
    rand_en = 1'b0;
    repeat (20) tick();

    // RD_LAT=3 instance: write 5A to addr 7, read it back.
    b_txn(1'b1, 3'd7, 8'h5A, lat, rd_seen);
    check("b_wr_lat", 32'(lat), 32'd2);
    b_txn(1'b0, 3'd7, 8'h00, lat, rd_seen);
    check("b_rd_strobe", 32'(rd_seen), 32'd1);
    check("b_rd_lat", 32'(lat), 32'd5);
    check("b_rdata", 32'(b_rdata), 32'h5A);
    check("b_busy", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
